// File: rtl/smem_pkg.sv
// Shared definitions for the backward-extension ring: token status codes,
// default read-number width and the slot scheduler state encoding.
package smem_pkg;

  localparam logic [5:0] ST_BUBBLE  = 6'b000000;
  localparam logic [5:0] ST_F_INIT  = 6'b000001;
  localparam logic [5:0] ST_F_RUN   = 6'b000010;
  localparam logic [5:0] ST_F_BREAK = 6'b000100;
  localparam logic [5:0] ST_BCK_INI = 6'b001000;
  localparam logic [5:0] ST_BCK_RUN = 6'b010000;
  localparam logic [5:0] ST_BCK_END = 6'b100000;

  localparam int RN_W_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [6:0] fwd_size;
    logic [6:0] backward_x;
    logic [6:0] min_intv;
  } job_attr_t;

  // A returning slot may be reused only if it carries nothing or a finished read.
  function automatic logic slot_is_free(input logic [5:0] status);
    return (status == ST_BUBBLE) || (status == ST_BCK_END);
  endfunction

endpackage

// File: rtl/bck_slot_scheduler_if.sv
// Job handshake, ring return/issue tokens and retire notification of the
// backward-extension slot scheduler.
interface bck_slot_scheduler_if #(
    parameter int RN_W = 10
);
    logic            req_valid;
    logic            req_ready;
    logic [RN_W-1:0] req_read_num;
    logic [6:0]      req_fwd_size;
    logic [6:0]      req_backward_x;
    logic [6:0]      req_min_intv;

    logic [5:0]      ret_status;
    logic [RN_W-1:0] ret_read_num;

    logic [5:0]      out_status;
    logic [RN_W-1:0] out_read_num;
    logic [6:0]      out_fwd_size;
    logic [6:0]      out_backward_x;
    logic [6:0]      out_min_intv;

    logic            done_valid;
    logic [RN_W-1:0] done_read_num;

    modport master (
        output req_valid, req_read_num, req_fwd_size, req_backward_x, req_min_intv,
        output ret_status, ret_read_num,
        input  req_ready,
        input  out_status, out_read_num, out_fwd_size, out_backward_x, out_min_intv,
        input  done_valid, done_read_num
    );

    modport slave (
        input  req_valid, req_read_num, req_fwd_size, req_backward_x, req_min_intv,
        input  ret_status, ret_read_num,
        output req_ready,
        output out_status, out_read_num, out_fwd_size, out_backward_x, out_min_intv,
        output done_valid, done_read_num
    );
endinterface

// File: rtl/sched_skid_reg.sv
// One-entry pending job register; refills in the same cycle it is drained so a
// steady job stream sustains one injection per cycle.
module sched_skid_reg #(
    parameter int W = 31
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         accept_en_i,
    input  logic         take_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         pend_valid_o,
    output logic [W-1:0] pend_data_o
);
    logic         pend_valid_q;
    logic [W-1:0] pend_data_q;
    logic         load;

    assign in_ready_o   = accept_en_i && (!pend_valid_q || take_i);
    assign load         = in_valid_i && in_ready_o;
    assign pend_valid_o = pend_valid_q;
    assign pend_data_o  = pend_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            if (load) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= in_data_i;
            end else if (take_i) begin
                pend_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/bck_slot_scheduler.sv
// Ring-entry slot scheduler: passes, retires or injects one token per cycle.
// Optional SCHED_PERF_CNT_EN adds injected/retired/full-cycle counters.
module bck_slot_scheduler
    import smem_pkg::*;
#(
    parameter int MAX_ACTIVE = 16,
    parameter int RN_W       = RN_W_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       stall_i,
    input  logic       enable_i,
    input  logic       drain_req_i,
    bck_slot_scheduler_if.slave bus,
    output logic [6:0] active_cnt_o,
    output logic       idle_o,
    output logic       err_o
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0] perf_injected_o,
    output logic [31:0] perf_retired_o,
    output logic [31:0] perf_full_cycles_o
`endif
);
    localparam int JW = RN_W + $bits(job_attr_t);

    sched_state_e    state_q;
    logic            idle_q, err_q, done_q;
    logic [6:0]      cnt_q, cnt_d, cnt_after_ret;
    logic [RN_W-1:0] done_rn_q;
    logic [5:0]      out_status_q;
    logic [RN_W-1:0] out_rn_q;
    job_attr_t       out_attr_q;

    logic            pend_valid, slot_free, retire, inject, accept_en;
    logic [JW-1:0]   pend_data;
    logic [RN_W-1:0] pend_rn;
    job_attr_t       pend_attr;

    assign slot_free = slot_is_free(bus.ret_status);
    assign retire    = !stall_i && (bus.ret_status == ST_BCK_END);
    assign accept_en = (state_q == S_RUN) && !stall_i;

    // Retiring from an empty ring is a protocol error; the count saturates at 0.
    assign cnt_after_ret = (retire && cnt_q != 7'd0) ? cnt_q - 7'd1 : cnt_q;
    assign inject = !stall_i && (state_q == S_RUN || state_q == S_DRAIN) &&
                    pend_valid && slot_free && (cnt_after_ret < 7'(MAX_ACTIVE));
    assign cnt_d  = cnt_after_ret + {6'd0, inject};

    assign {pend_rn, pend_attr} = pend_data;

    sched_skid_reg #(.W(JW)) u_pend (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .accept_en_i  (accept_en),
        .take_i       (inject),
        .in_valid_i   (bus.req_valid),
        .in_ready_o   (bus.req_ready),
        .in_data_i    ({bus.req_read_num, bus.req_fwd_size, bus.req_backward_x, bus.req_min_intv}),
        .pend_valid_o (pend_valid),
        .pend_data_o  (pend_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idle_q  <= 1'b1;
        end else if (!stall_i) begin
            unique case (state_q)
                S_IDLE:  if (enable_i) begin state_q <= S_RUN; idle_q <= 1'b0; end
                S_RUN:   if (drain_req_i || !enable_i) state_q <= S_DRAIN;
                S_DRAIN: if (cnt_q == 7'd0 && !pend_valid) begin state_q <= S_IDLE; idle_q <= 1'b1; end
                default: begin state_q <= S_IDLE; idle_q <= 1'b1; end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            done_rn_q    <= '0;
            out_status_q <= ST_BUBBLE;
            out_rn_q     <= '0;
            out_attr_q   <= '0;
        end else if (!stall_i) begin
            cnt_q  <= cnt_d;
            err_q  <= err_q || (retire && cnt_q == 7'd0);
            done_q <= retire;
            if (retire) done_rn_q <= bus.ret_read_num;
            if (inject) begin
                out_status_q <= ST_BCK_INI;
                out_rn_q     <= pend_rn;
                out_attr_q   <= pend_attr;
            end else if (retire) begin
                out_status_q <= ST_BUBBLE;
                out_rn_q     <= '0;
                out_attr_q   <= '0;
            end else begin
                out_status_q <= bus.ret_status;
                out_rn_q     <= bus.ret_read_num;
                out_attr_q   <= '0;
            end
        end
    end

    assign bus.out_status     = out_status_q;
    assign bus.out_read_num   = out_rn_q;
    assign bus.out_fwd_size   = out_attr_q.fwd_size;
    assign bus.out_backward_x = out_attr_q.backward_x;
    assign bus.out_min_intv   = out_attr_q.min_intv;
    // A pending pulse is held across a stall and shows once the stall drops.
    assign bus.done_valid     = done_q && !stall_i;
    assign bus.done_read_num  = done_rn_q;
    assign active_cnt_o       = cnt_q;
    assign idle_o             = idle_q;
    assign err_o              = err_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_inj_q, perf_ret_q, perf_full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_inj_q  <= '0;
            perf_ret_q  <= '0;
            perf_full_q <= '0;
        end else if (!stall_i) begin
            if (inject) perf_inj_q <= perf_inj_q + 32'd1;
            if (retire) perf_ret_q <= perf_ret_q + 32'd1;
            if (pend_valid && slot_free && cnt_q == 7'(MAX_ACTIVE)) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_injected_o    = perf_inj_q;
    assign perf_retired_o     = perf_ret_q;
    assign perf_full_cycles_o = perf_full_q;
`endif
endmodule

// File: tb/tb_bck_slot_scheduler.sv
// Directed bench for bck_slot_scheduler built with MAX_ACTIVE=2.
module tb_bck_slot_scheduler;
  localparam logic [5:0] BUBBLE  = 6'b000000;
  localparam logic [5:0] BCK_INI = 6'b001000;
  localparam logic [5:0] BCK_RUN = 6'b010000;
  localparam logic [5:0] BCK_END = 6'b100000;

  logic clk = 1'b0;
  logic rst_n, stall, enable, drain_req;
  logic [6:0] active_cnt;
  logic idle, err;
  int checks = 0;
  int errors = 0;

  bck_slot_scheduler_if #(.RN_W(10)) bus ();

  bck_slot_scheduler #(.MAX_ACTIVE(2), .RN_W(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .enable_i(enable),
    .drain_req_i(drain_req), .bus(bus), .active_cnt_o(active_cnt),
    .idle_o(idle), .err_o(err)
`ifdef SCHED_PERF_CNT_EN
    , .perf_injected_o(), .perf_retired_o(), .perf_full_cycles_o()
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ret(input logic [5:0] st, input logic [9:0] rn);
    bus.ret_status = st;
    bus.ret_read_num = rn;
  endtask

  task automatic set_req(input logic v, input logic [9:0] rn, input logic [6:0] f,
                         input logic [6:0] b, input logic [6:0] m);
    bus.req_valid = v;
    bus.req_read_num = rn;
    bus.req_fwd_size = f;
    bus.req_backward_x = b;
    bus.req_min_intv = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; enable = 0; drain_req = 0;
    set_ret(BUBBLE, 10'd0);
    set_req(1'b0, 10'd0, 7'd0, 7'd0, 7'd0);
    #12;
    checks++; if (bus.out_status !== BUBBLE) begin errors++; $display("FAIL reset_status got %b exp %b", bus.out_status, BUBBLE); end
    checks++; if ({idle, err, active_cnt} !== {1'b1, 1'b0, 7'd0}) begin errors++; $display("FAIL reset_flags got idle=%0b err=%0b cnt=%0d exp 1 0 0", idle, err, active_cnt); end
    checks++; if ({bus.req_ready, bus.done_valid} !== 2'b00) begin errors++; $display("FAIL reset_hs got ready=%0b done=%0b exp 0 0", bus.req_ready, bus.done_valid); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_inject();
    enable = 1'b1;
    tick();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL run_idle got %0b exp 0", idle); end
    set_req(1'b1, 10'd5, 7'd20, 7'd30, 7'd1);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    tick();
    checks++; if ({bus.out_status, bus.out_read_num, bus.out_fwd_size, bus.out_backward_x, bus.out_min_intv} !== {BCK_INI, 10'd5, 7'd20, 7'd30, 7'd1})
      begin errors++; $display("FAIL single_tok got st=%b rn=%0d f=%0d b=%0d m=%0d exp 001000 5 20 30 1", bus.out_status, bus.out_read_num, bus.out_fwd_size, bus.out_backward_x, bus.out_min_intv); end
    checks++; if (active_cnt !== 7'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", active_cnt); end
    set_ret(BCK_END, 10'd5);
    tick();
    checks++; if ({bus.done_valid, bus.done_read_num, active_cnt} !== {1'b1, 10'd5, 7'd0}) begin errors++; $display("FAIL single_retire got done=%0b rn=%0d cnt=%0d exp 1 5 0", bus.done_valid, bus.done_read_num, active_cnt); end
    set_ret(BUBBLE, 10'd0);
    tick();
    checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %0b exp 0", bus.done_valid); end
  endtask

  task automatic test_max_active();
    set_req(1'b1, 10'd6, 7'd1, 7'd2, 7'd3);
    tick();
    set_req(1'b1, 10'd7, 7'd4, 7'd5, 7'd6);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b exp 1", bus.req_ready); end
    tick();
    checks++; if ({bus.out_status, bus.out_read_num} !== {BCK_INI, 10'd6}) begin errors++; $display("FAIL b2b_tok6 got %b/%0d exp 001000/6", bus.out_status, bus.out_read_num); end
    set_req(1'b1, 10'd8, 7'd7, 7'd8, 7'd9);
    tick();
    checks++; if ({bus.out_status, bus.out_read_num, active_cnt} !== {BCK_INI, 10'd7, 7'd2}) begin errors++; $display("FAIL b2b_tok7 got %b/%0d cnt=%0d exp 001000/7 cnt=2", bus.out_status, bus.out_read_num, active_cnt); end
    set_req(1'b1, 10'd9, 7'd0, 7'd0, 7'd0);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", bus.req_ready); end
    tick();
    checks++; if ({bus.out_status, active_cnt} !== {BUBBLE, 7'd2}) begin errors++; $display("FAIL full_noinj got %b cnt=%0d exp 000000 cnt=2", bus.out_status, active_cnt); end
    bus.req_valid = 1'b0;
    set_ret(BCK_END, 10'd7);
    tick();
    checks++; if ({bus.done_valid, bus.done_read_num} !== {1'b1, 10'd7}) begin errors++; $display("FAIL full_done got %0b/%0d exp 1/7", bus.done_valid, bus.done_read_num); end
    checks++; if ({bus.out_status, bus.out_read_num, bus.out_fwd_size, active_cnt} !== {BCK_INI, 10'd8, 7'd7, 7'd2}) begin errors++; $display("FAIL full_reuse got %b/%0d f=%0d cnt=%0d exp 001000/8 f=7 cnt=2", bus.out_status, bus.out_read_num, bus.out_fwd_size, active_cnt); end
    set_ret(BUBBLE, 10'd0);
    tick();
  endtask

  task automatic test_bck_run_pass();
    set_ret(BCK_END, 10'd6);
    tick();
    checks++; if (active_cnt !== 7'd1) begin errors++; $display("FAIL run_pre_cnt got %0d exp 1", active_cnt); end
    set_ret(BCK_RUN, 10'd100);
    set_req(1'b1, 10'd10, 7'd11, 7'd12, 7'd13);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ret(BCK_RUN, 10'(101 + i));
      tick();
      checks++; if ({bus.out_status, bus.out_read_num, bus.out_fwd_size, active_cnt} !== {BCK_RUN, 10'(101 + i), 7'd0, 7'd1})
        begin errors++; $display("FAIL run_pass%0d got %b/%0d f=%0d cnt=%0d exp 010000/%0d f=0 cnt=1", i, bus.out_status, bus.out_read_num, bus.out_fwd_size, active_cnt, 101 + i); end
    end
    set_ret(BUBBLE, 10'd0);
    tick();
    checks++; if ({bus.out_status, bus.out_read_num, bus.out_min_intv, active_cnt} !== {BCK_INI, 10'd10, 7'd13, 7'd2}) begin errors++; $display("FAIL run_after got %b/%0d m=%0d cnt=%0d exp 001000/10 m=13 cnt=2", bus.out_status, bus.out_read_num, bus.out_min_intv, active_cnt); end
  endtask

  task automatic test_stall();
    set_ret(BCK_END, 10'd8);
    tick();
    set_ret(BCK_RUN, 10'd55);
    set_req(1'b1, 10'd11, 7'd3, 7'd4, 7'd5);
    tick();
    bus.req_valid = 1'b0;
    stall = 1'b1;
    set_ret(BCK_END, 10'd77);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.out_status, bus.out_read_num, bus.done_valid, active_cnt, bus.req_ready} !== {BCK_RUN, 10'd55, 1'b0, 7'd1, 1'b0})
        begin errors++; $display("FAIL stall%0d got %b/%0d done=%0b cnt=%0d rdy=%0b exp 010000/55 0 1 0", i, bus.out_status, bus.out_read_num, bus.done_valid, active_cnt, bus.req_ready); end
    end
    stall = 1'b0;
    set_ret(BUBBLE, 10'd0);
    tick();
    checks++; if ({bus.out_status, bus.out_read_num, bus.out_backward_x, active_cnt, bus.done_valid} !== {BCK_INI, 10'd11, 7'd4, 7'd2, 1'b0})
      begin errors++; $display("FAIL stall_after got %b/%0d b=%0d cnt=%0d done=%0b exp 001000/11 b=4 cnt=2 done=0", bus.out_status, bus.out_read_num, bus.out_backward_x, active_cnt, bus.done_valid); end
  endtask

  task automatic test_drain();
    set_req(1'b1, 10'd12, 7'd1, 7'd1, 7'd1);
    tick();
    bus.req_valid = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    set_req(1'b1, 10'd13, 7'd2, 7'd2, 7'd2);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %0b exp 0", bus.req_ready); end
    set_ret(BCK_END, 10'd10);
    tick();
    checks++; if ({bus.out_status, bus.out_read_num, bus.done_read_num, active_cnt} !== {BCK_INI, 10'd12, 10'd10, 7'd2})
      begin errors++; $display("FAIL drain_inj got %b/%0d done_rn=%0d cnt=%0d exp 001000/12 10 2", bus.out_status, bus.out_read_num, bus.done_read_num, active_cnt); end
    set_ret(BCK_END, 10'd11);
    tick();
    set_ret(BCK_END, 10'd12);
    tick();
    checks++; if ({active_cnt, idle, bus.req_ready} !== {7'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL drain_empty got cnt=%0d idle=%0b rdy=%0b exp 0 0 0", active_cnt, idle, bus.req_ready); end
    bus.req_valid = 1'b0;
    set_ret(BUBBLE, 10'd0);
    tick();
    checks++; if ({idle, err} !== 2'b10) begin errors++; $display("FAIL drain_idle got idle=%0b err=%0b exp 1 0", idle, err); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_err();
    set_ret(BCK_END, 10'd9);
    tick();
    checks++; if ({err, active_cnt, bus.done_valid} !== {1'b1, 7'd0, 1'b1}) begin errors++; $display("FAIL err_set got err=%0b cnt=%0d done=%0b exp 1 0 1", err, active_cnt, bus.done_valid); end
    set_ret(BUBBLE, 10'd0);
    tick();
    tick();
    checks++; if ({err, active_cnt} !== {1'b1, 7'd0}) begin errors++; $display("FAIL err_sticky got err=%0b cnt=%0d exp 1 0", err, active_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_inject();
    test_max_active();
    test_bck_run_pass();
    test_stall();
    test_drain();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end
endmodule
